// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//   Command issue stage in front of the register-file/ALU stage. Buffers
//   register-write and ALU commands in a DEPTH-entry FIFO. Issues at most one
//   command per clock into registered output fields. Optionally inserts a
//   one-cycle bubble when an ALU command reads the register written by the
//   write issued in the immediately preceding cycle.
//
// Build option:
//   ALU_CMD_ISSUER_HAZARD_EN - define to enable hazard detection and bubbles.
//                              When undefined, commands issue back-to-back
//                              and bubble_count stays at 0.
//
// Ports:
//   clock, reset        - single clock; synchronous active-high reset
//   in_valid/in_ready   - command handshake (accept on in_valid && in_ready)
//   in_write            - 1 = register write, 0 = ALU/read command
//   in_addr, in_data    - write address/data (in_addr is the read address
//                         when in_sel = 1)
//   in_addrop1/2        - ALU operand addresses
//   in_opcode, in_sel   - ALU operation and output select
//   hold                - blocks issue; the FIFO still accepts commands
//   addr, data, addrop1, addrop2, opcode, sel
//                       - registered command fields; hold value when idle
//   we                  - high only in a cycle that issues a write
//   issue_valid         - a command was issued this cycle
//   empty               - FIFO holds no entries
//   issued_count        - commands issued since reset (wraps)
//   bubble_count        - hazard bubbles since reset (saturates)
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_write,
    input  logic [3:0] in_addr,
    input  logic [3:0] in_data,
    input  logic [3:0] in_addrop1,
    input  logic [3:0] in_addrop2,
    input  logic [1:0] in_opcode,
    input  logic       in_sel,
    input  logic       hold,
    output logic [3:0] addr,
    output logic [3:0] data,
    output logic [3:0] addrop1,
    output logic [3:0] addrop2,
    output logic [1:0] opcode,
    output logic       sel,
    output logic       we,
    output logic       issue_valid,
    output logic       empty,
    output logic [7:0] issued_count,
    output logic [7:0] bubble_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = 20;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [EW-1:0] in_entry;
    logic [EW-1:0] head;
    logic          head_write;
    logic [3:0]    head_addr;
    logic [3:0]    head_data;
    logic [3:0]    head_op1;
    logic [3:0]    head_op2;
    logic [1:0]    head_opcode;
    logic          head_sel;

    logic push;
    logic pop;
    logic hazard;

    assign in_ready = (count != CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;

    assign in_entry = {in_write, in_addr, in_data, in_addrop1, in_addrop2,
                       in_opcode, in_sel};
    assign head     = mem[rd_ptr];
    assign {head_write, head_addr, head_data, head_op1, head_op2,
            head_opcode, head_sel} = head;

`ifdef ALU_CMD_ISSUER_HAZARD_EN
    // The issued write is still visible in the output registers (we/addr),
    // so comparing against them catches a read of the register being written
    // this cycle. A bubble clears we, so the stall lasts one cycle only.
    assign hazard = !empty && !head_write && issue_valid && we &&
                    ((head_op1 == addr) || (head_op2 == addr) ||
                     (head_sel && (head_addr == addr)));
`else
    assign hazard = 1'b0;
`endif

    assign pop = !empty && !hold && !hazard;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr         <= '0;
            data         <= '0;
            addrop1      <= '0;
            addrop2      <= '0;
            opcode       <= '0;
            sel          <= 1'b0;
            we           <= 1'b0;
            issue_valid  <= 1'b0;
            issued_count <= '0;
            bubble_count <= '0;
        end else begin
            if (pop) begin
                addr         <= head_addr;
                data         <= head_data;
                addrop1      <= head_op1;
                addrop2      <= head_op2;
                opcode       <= head_opcode;
                sel          <= head_sel;
                we           <= head_write;
                issue_valid  <= 1'b1;
                issued_count <= issued_count + 8'd1;
            end else begin
                we           <= 1'b0;
                issue_valid  <= 1'b0;
            end
            if (hazard && (bubble_count != '1)) begin
                bubble_count <= bubble_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
//   Self-checking bench for alu_cmd_issuer. A queue-based reference model
//   predicts every output after each clock edge. Directed scenarios are
//   followed by a randomized run. Build with ALU_CMD_ISSUER_HAZARD_EN defined
//   or undefined to match the RTL build.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_write;
    logic [3:0] in_addr;
    logic [3:0] in_data;
    logic [3:0] in_addrop1;
    logic [3:0] in_addrop2;
    logic [1:0] in_opcode;
    logic       in_sel;
    logic       hold;
    logic [3:0] addr;
    logic [3:0] data;
    logic [3:0] addrop1;
    logic [3:0] addrop2;
    logic [1:0] opcode;
    logic       sel;
    logic       we;
    logic       issue_valid;
    logic       empty;
    logic [7:0] issued_count;
    logic [7:0] bubble_count;

    alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
        .in_addrop1(in_addrop1), .in_addrop2(in_addrop2),
        .in_opcode(in_opcode), .in_sel(in_sel), .hold(hold),
        .addr(addr), .data(data), .addrop1(addrop1), .addrop2(addrop2),
        .opcode(opcode), .sel(sel), .we(we), .issue_valid(issue_valid),
        .empty(empty), .issued_count(issued_count),
        .bubble_count(bubble_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       wr;
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] o1;
        logic [3:0] o2;
        logic [1:0] opc;
        logic       s;
    } cmd_t;

    cmd_t q[$];

    // Reference output state
    logic [3:0] m_addr, m_data, m_op1, m_op2;
    logic [1:0] m_opc;
    logic       m_sel, m_we, m_iv;
    int         m_issued;
    int         m_bub;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = '0; m_data = '0; m_op1 = '0; m_op2 = '0; m_opc = '0;
        m_sel = 1'b0; m_we = 1'b0; m_iv = 1'b0; m_issued = 0; m_bub = 0;
    endtask

    task automatic check_all();
        chk("addr", 8'(addr), 8'(m_addr));
        chk("data", 8'(data), 8'(m_data));
        chk("addrop1", 8'(addrop1), 8'(m_op1));
        chk("addrop2", 8'(addrop2), 8'(m_op2));
        chk("opcode", 8'(opcode), 8'(m_opc));
        chk("sel", 8'(sel), 8'(m_sel));
        chk("we", 8'(we), 8'(m_we));
        chk("issue_valid", 8'(issue_valid), 8'(m_iv));
        chk("in_ready", 8'(in_ready), 8'(q.size() != DEPTH));
        chk("empty", 8'(empty), 8'(q.size() == 0));
        chk("issued_count", issued_count, 8'(m_issued));
        chk("bubble_count", bubble_count, 8'(m_bub));
    endtask

    // One clock: predict from the current inputs and model state, take the
    // edge, update the model and compare every output.
    task automatic tick();
        cmd_t c, h;
        bit   acc, haz, pp;
        c   = '{in_write, in_addr, in_data, in_addrop1, in_addrop2, in_opcode, in_sel};
        acc = in_valid && (q.size() < DEPTH);
        haz = 1'b0;
`ifdef ALU_CMD_ISSUER_HAZARD_EN
        if (q.size() > 0 && !q[0].wr && m_iv && m_we &&
            (q[0].o1 == m_addr || q[0].o2 == m_addr || (q[0].s && q[0].a == m_addr)))
            haz = 1'b1;
`endif
        pp = (q.size() > 0) && !hold && !haz;
        @(posedge clock);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (pp) begin
                h = q.pop_front();
                m_addr = h.a; m_data = h.d; m_op1 = h.o1; m_op2 = h.o2;
                m_opc = h.opc; m_sel = h.s; m_we = h.wr; m_iv = 1'b1;
                m_issued = (m_issued + 1) % 256;
            end else begin
                m_we = 1'b0; m_iv = 1'b0;
            end
            if (haz && m_bub < 255) m_bub++;
            if (acc) q.push_back(c);
        end
        check_all();
    endtask

    task automatic set_cmd(input logic w, input logic [3:0] a, input logic [3:0] d,
                           input logic [3:0] o1, input logic [3:0] o2,
                           input logic [1:0] opc, input logic s);
        in_valid = 1'b1; in_write = w; in_addr = a; in_data = d;
        in_addrop1 = o1; in_addrop2 = o2; in_opcode = opc; in_sel = s;
    endtask

    initial begin
        bit acc5;
        reset = 1'b1; hold = 1'b0; in_valid = 1'b0; in_write = 1'b0;
        in_addr = '0; in_data = '0; in_addrop1 = '0; in_addrop2 = '0;
        in_opcode = '0; in_sel = 1'b0;
        model_reset();

        // Reset then idle
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_in_ready", 8'(in_ready), 8'd1);
        chk("idle_empty", 8'(empty), 8'd1);
        chk("idle_issue_valid", 8'(issue_valid), 8'd0);

        // Three writes back to back
        set_cmd(1'b1, 4'd0, 4'd10, 4'd0, 4'd0, 2'd0, 1'b0); tick();
        set_cmd(1'b1, 4'd1, 4'd12, 4'd0, 4'd0, 2'd0, 1'b0); tick();
        chk("w0_we", 8'(we), 8'd1);
        chk("w0_data", 8'(data), 8'd10);
        set_cmd(1'b1, 4'd2, 4'd5, 4'd0, 4'd0, 2'd0, 1'b0); tick();
        chk("w1_addr", 8'(addr), 8'd1);
        chk("w1_data", 8'(data), 8'd12);
        in_valid = 1'b0; tick();
        chk("w2_addr", 8'(addr), 8'd2);
        chk("w2_data", 8'(data), 8'd5);
        tick();
        chk("writes_issued", issued_count, 8'd3);
        chk("writes_bubbles", bubble_count, 8'd0);

        // Write then dependent ALU command
        set_cmd(1'b1, 4'd4, 4'd14, 4'd0, 4'd0, 2'd0, 1'b0); tick();
        set_cmd(1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 2'd0, 1'b0); tick();
        chk("haz_write_we", 8'(we), 8'd1);
        chk("haz_write_addr", 8'(addr), 8'd4);
        in_valid = 1'b0; tick();
`ifdef ALU_CMD_ISSUER_HAZARD_EN
        chk("haz_bubble_iv", 8'(issue_valid), 8'd0);
        tick();
        chk("haz_alu_iv", 8'(issue_valid), 8'd1);
        chk("haz_alu_we", 8'(we), 8'd0);
        chk("haz_alu_op2", 8'(addrop2), 8'd4);
        chk("haz_bubble_count", bubble_count, 8'd1);
`else
        chk("nohaz_alu_iv", 8'(issue_valid), 8'd1);
        chk("nohaz_alu_we", 8'(we), 8'd0);
        chk("nohaz_alu_op2", 8'(addrop2), 8'd4);
        tick();
        chk("nohaz_bubble_count", bubble_count, 8'd0);
`endif
        tick();

        // Hold while filling the FIFO, then release
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 4'(8 + i), 4'(i + 1), 4'd0, 4'd0, 2'd0, 1'b0);
            tick();
        end
        chk("hold_full_in_ready", 8'(in_ready), 8'd0);
        set_cmd(1'b1, 4'd12, 4'd7, 4'd0, 4'd0, 2'd0, 1'b0);
        tick();
        chk("hold_still_full", 8'(in_ready), 8'd0);
        hold = 1'b0;
        acc5 = 1'b0;
        for (int k = 0; k < 10 && !acc5; k++) begin
            acc5 = in_ready;
            tick();
        end
        chk("fifth_accepted", 8'(acc5), 8'd1);
        in_valid = 1'b0;
        repeat (6) tick();
        chk("hold_drain_empty", 8'(empty), 8'd1);

        // Reset with buffered commands
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 4'(5 + i), 4'(9 + i), 4'd0, 4'd0, 2'd0, 1'b0);
            tick();
        end
        in_valid = 1'b0; hold = 1'b0; reset = 1'b1;
        tick();
        chk("rst_we", 8'(we), 8'd0);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_issued", issued_count, 8'd0);
        chk("rst_bubbles", bubble_count, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_issue", 8'(issue_valid), 8'd0);
        end

        // Randomized traffic with small address range to provoke hazards
        for (int n = 0; n < 500; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_write   = 1'($urandom_range(0, 1));
            in_addr    = 4'($urandom_range(0, 3));
            in_data    = 4'($urandom);
            in_addrop1 = 4'($urandom_range(0, 3));
            in_addrop2 = 4'($urandom_range(0, 3));
            in_opcode  = 2'($urandom);
            in_sel     = 1'($urandom_range(0, 1));
            hold       = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; hold = 1'b0; in_valid = 1'b0;
        repeat (8) tick();
        chk("final_empty", 8'(empty), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command issue stage placed directly upstream of the register-file/ALU stage. It accepts register-write and ALU-operation commands through a valid/ready handshake, buffers them in a small FIFO, and drives the register-file/ALU stage's `addr`, `data`, `we`, `addrop1`, `addrop2`, `opcode` and `sel` inputs with at most one command per clock. It also inserts a one-cycle bubble when an ALU command would read a register written in the immediately preceding issue cycle.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2, minimum 2.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  command present on the `in_*` fields.
- `in_ready`  out  1  FIFO not full; the command is accepted on an edge where `in_valid && in_ready`.
- `in_write`  in  1  command kind: 1 = register write, 0 = ALU/read command.
- `in_addr`  in  4  write address, or read address when `in_sel`=1.
- `in_data`  in  4  write data.
- `in_addrop1`, `in_addrop2`  in  4 each  ALU operand addresses.
- `in_opcode`  in  2  ALU operation.
- `in_sel`  in  1  output select forwarded to the downstream stage.
- `hold`  in  1  freezes issue; the FIFO keeps accepting commands.
- `addr`, `data`, `addrop1`, `addrop2`  out  4 each  registered command fields.
- `opcode`  out  2  registered.
- `sel`  out  1  registered.
- `we`  out  1  registered; high only in a cycle that issues a write command.
- `issue_valid`  out  1  a command was issued this cycle.
- `empty`  out  1  FIFO holds no entries.
- `issued_count`  out  8  commands issued since reset; wraps 255→0.
- `bubble_count`  out  8  hazard bubbles inserted since reset; saturates at 255.

## Operation
- FIFO storage:
  - Read/write pointers of `$clog2(DEPTH)` bits plus an occupancy count of 0..DEPTH.
  - `in_ready = (count != DEPTH)`. This is evaluated on the registered count, so no push is accepted while full, even in a cycle that pops.
- Pop condition: `!empty && !hold && !hazard`.
  - On a pop, all head fields load into the output registers.
  - `we` loads `in_write` of the head entry.
  - `issue_valid` is set to 1.
  - `issued_count` increments.
- No-pop cycle:
  - `we` and `issue_valid` go to 0.
  - `addr`, `data`, `addrop1`, `addrop2`, `opcode` and `sel` hold their last values, so the downstream select and read path stay stable.
- Hazard (macro-dependent, see Configuration): the head is a non-write command, the previous cycle issued a write (`issue_valid && we`) to address A, and any of the following holds:
  - `addrop1` == A;
  - `addrop2` == A;
  - head `sel`=1 and head `addr` == A.
- Bubble: in a hazard cycle no pop occurs and `bubble_count` increments (saturating). Because the bubble clears the previous-write condition, the hazard lasts exactly one cycle.
- Command kinds that never hazard:
  - write after write;
  - a read after a write to a different address.
- Simultaneous push and pop with `0 < count < DEPTH`: count is unchanged and both pointers advance.
- Reset: every output register, the pointers, the count and both counters are cleared to 0. Afterwards `in_ready`=1 and `empty`=1. Reset asserted mid-stream discards all buffered commands, and no `we` pulse escapes in the cycle after the reset edge.

## Timing
- A command accepted at edge N is issued at edge N+1 at the earliest; outputs are valid during cycle N+1. Latency is one edge from accept to output when the FIFO is empty.
- A hazard adds exactly one cycle.
- `hold` takes effect at the next edge: a `hold` that is high at edge N blocks the pop at edge N.
- Throughput is one command per cycle when there is no hazard or hold.
- `in_ready` and `empty` are combinational from the registered count only, with no path from `in_valid`.

## Configuration
- `ALU_CMD_ISSUER_HAZARD_EN` defined: hazard detection and bubble insertion are active as described above.
- Not defined: the hazard term is forced to 0. Commands issue back-to-back regardless of address overlap, and `bubble_count` stays at 0.

## Test plan
- Reset, then idle for 3 cycles:
  - required: all outputs 0, `in_ready`=1, `empty`=1.
- Push writes (0,10), (1,12), (2,5) on consecutive cycles:
  - required: `we`=1 with `addr`/`data` = 0/10, 1/12, 2/5 on the three cycles after each accept;
  - required: `issued_count`=3 and `bubble_count`=0.
- Push write (4,14), then ALU `addrop1`=0, `addrop2`=4, `opcode`=0 back-to-back, macro defined:
  - required: a bubble cycle between them (`issue_valid`=0), then the ALU command issues;
  - required: `bubble_count`=1.
- Same stimulus with the macro undefined:
  - required: the ALU command issues in the cycle directly after the write;
  - required: `bubble_count`=0.
- Hold `hold`=1 and push 5 commands with `DEPTH`=4:
  - required: the first 4 are accepted and `in_ready` drops to 0 on the 5th;
  - release `hold`: the 4 issue in order on consecutive cycles; the 5th is accepted once `in_ready` returns to 1 and issues after them.
- Assert `reset` with 3 commands buffered:
  - required: `we`=0 on the next cycle, `empty`=1 and both counters 0;
  - required: no buffered command issues afterwards.
